// File: rtl/i2c_master_scheduler.sv
// i2c_master_scheduler: round-robin arbiter that sequences three requesters'
// single-byte read/write transactions onto one I2C byte master.
module i2c_master_scheduler #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [2:0]  req_rw,
    input  logic [20:0] req_addr,
    input  logic [23:0] req_wdata,
    output logic [2:0]  gnt,
    output logic [2:0]  done,
    output logic [2:0]  err,
    output logic [7:0]  rdata,
    output logic        m_start,
    output logic [7:0]  m_data,
    input  logic        m_idle,
    input  logic        m_ack,
    input  logic        m_nack,
    input  logic [7:0]  m_rdata
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, GRANT, START, ADDR, DATA, WAIT, DONE} state_t;

    state_t        state_q;
    logic [1:0]    last_q, idx_q, c1, c2, win;
    logic [TW-1:0] cnt_q;
    logic [2:0]    gnt_q, done_q, err_q;
    logic [7:0]    rdata_q, rd_q, rd_d, m_data_q, wdata_q, sel_wdata;
    logic [6:0]    addr_q, sel_addr;
    logic          rw_q, m_start_q, tmo, act, to_done, fail;

    function automatic logic [1:0] nxt(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    assign c1  = nxt(last_q);
    assign c2  = nxt(c1);
    assign win = req[c1] ? c1 : req[c2] ? c2 : last_q;

    assign sel_addr  = (win == 2'd2) ? req_addr[20:14] : (win == 2'd1) ? req_addr[13:7] : req_addr[6:0];
    assign sel_wdata = (win == 2'd2) ? req_wdata[23:16] : (win == 2'd1) ? req_wdata[15:8] : req_wdata[7:0];

    // The cycle that would bring the count to TIMEOUT is the last one allowed.
    assign tmo     = cnt_q == TW'(TIMEOUT - 1);
    assign act     = (state_q == ADDR) || (state_q == DATA);
    assign to_done = (state_q == WAIT) ? (m_idle || tmo) : act && (m_nack || (!m_ack && tmo));
    assign fail    = to_done && !(state_q == WAIT && m_idle);
    assign rd_d    = (state_q == WAIT && m_idle && rw_q) ? m_rdata : rd_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            last_q    <= 2'd2;
            idx_q     <= 2'd0;
            cnt_q     <= '0;
            gnt_q     <= 3'b000;
            done_q    <= 3'b000;
            err_q     <= 3'b000;
            rdata_q   <= 8'h00;
            rd_q      <= 8'h00;
            m_data_q  <= 8'h00;
            m_start_q <= 1'b0;
            addr_q    <= 7'h00;
            rw_q      <= 1'b0;
            wdata_q   <= 8'h00;
        end else if (to_done) begin
            state_q <= DONE;
            cnt_q   <= '0;
            done_q  <= gnt_q;
            err_q   <= fail ? gnt_q : 3'b000;
            rdata_q <= rw_q ? rd_d : 8'h00;
            rd_q    <= rd_d;
        end else begin
            case (state_q)
                IDLE: if (|req && m_idle) begin
                    state_q <= GRANT;
                    gnt_q   <= 3'b001 << win;
                    idx_q   <= win;
                    addr_q  <= sel_addr;
                    rw_q    <= req_rw[win];
                    wdata_q <= sel_wdata;
                    rd_q    <= 8'h00;
                end
                GRANT: begin
                    state_q   <= START;
                    m_start_q <= 1'b1;
                    m_data_q  <= {addr_q, rw_q};
                end
                START: begin
                    state_q   <= ADDR;
                    m_start_q <= 1'b0;
                end
                ADDR: if (m_ack) begin
                    state_q <= rw_q ? WAIT : DATA;
                    cnt_q   <= '0;
                    if (!rw_q) m_data_q <= wdata_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                DATA: if (m_ack) begin
                    state_q <= WAIT;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                WAIT: cnt_q <= cnt_q + 1'b1;
                DONE: begin
                    state_q <= IDLE;
                    gnt_q   <= 3'b000;
                    done_q  <= 3'b000;
                    err_q   <= 3'b000;
                    rdata_q <= 8'h00;
                    last_q  <= idx_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign m_start = m_start_q;
    assign m_data  = m_data_q;
endmodule

// File: tb/tb_i2c_master_scheduler.sv
// tb_i2c_master_scheduler: directed checks of write, read, NACK, round-robin,
// timeout and mid-transaction reset behaviour.
module tb_i2c_master_scheduler;
    logic        clk = 1'b0, rst = 1'b0;
    logic [2:0]  req = 3'b000, req_rw = 3'b010;
    logic [20:0] req_addr = {7'h33, 7'h11, 7'h2A};
    logic [23:0] req_wdata = {8'h77, 8'hEE, 8'hC3};
    logic [2:0]  gnt, done, err;
    logic [7:0]  rdata, m_data, m_rdata = 8'h00;
    logic        m_start, m_idle = 1'b1, m_ack = 1'b0, m_nack = 1'b0;
    int          passed = 0, total = 0, n;
    logic [2:0]  rr [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

    i2c_master_scheduler #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
        .m_start(m_start), .m_data(m_data), .m_idle(m_idle), .m_ack(m_ack),
        .m_nack(m_nack), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        // reset
        tick();
        tick();
        chk("rst_gnt", 8'(gnt), 8'h00);
        chk("rst_done", 8'(done), 8'h00);
        chk("rst_m_start", 8'(m_start), 8'h00);
        chk("rst_m_data", m_data, 8'h00);
        rst = 1'b1;
        // write from requester 0
        req = 3'b001;
        tick();
        chk("wr_gnt", 8'(gnt), 8'h01);
        tick();
        req = 3'b000;
        chk("wr_m_start", 8'(m_start), 8'h01);
        chk("wr_m_data_addr", m_data, 8'h54);
        tick();
        chk("wr_m_start_low", 8'(m_start), 8'h00);
        m_ack = 1'b1;
        tick();
        chk("wr_m_data_byte", m_data, 8'hC3);
        m_idle = 1'b0;
        tick();
        m_ack = 1'b0;
        chk("wr_wait_no_done", 8'(done), 8'h00);
        m_idle = 1'b1;
        tick();
        chk("wr_done", 8'(done), 8'h01);
        chk("wr_err", 8'(err), 8'h00);
        chk("wr_rdata", rdata, 8'h00);
        tick();
        chk("wr_done_pulse", 8'(done), 8'h00);
        chk("wr_gnt_clear", 8'(gnt), 8'h00);
        // read from requester 1
        req = 3'b010;
        tick();
        req = 3'b000;
        chk("rd_gnt", 8'(gnt), 8'h02);
        tick();
        chk("rd_m_data_addr", m_data, 8'h23);
        tick();
        m_ack = 1'b1;
        m_idle = 1'b0;
        tick();
        m_ack = 1'b0;
        chk("rd_skip_data", m_data, 8'h23);
        chk("rd_wait_no_done", 8'(done), 8'h00);
        m_idle = 1'b1;
        m_rdata = 8'h5A;
        tick();
        m_rdata = 8'h00;
        chk("rd_done", 8'(done), 8'h02);
        chk("rd_rdata", rdata, 8'h5A);
        tick();
        chk("rd_rdata_clear", rdata, 8'h00);
        // NACK in ADDR from requester 2
        req = 3'b100;
        tick();
        req = 3'b000;
        chk("nk_gnt", 8'(gnt), 8'h04);
        tick();
        tick();
        m_nack = 1'b1;
        tick();
        m_nack = 1'b0;
        chk("nk_done", 8'(done), 8'h04);
        chk("nk_err", 8'(err), 8'h04);
        chk("nk_no_data", m_data, 8'h66);
        tick();
        chk("nk_gnt_clear", 8'(gnt), 8'h00);
        // round-robin with all requesters active, each transaction NACKed quickly
        req = 3'b111;
        m_nack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (gnt === 3'b000 && n < 20) begin
                tick();
                n++;
            end
            chk("rr_gnt", 8'(gnt), 8'(rr[i]));
            n = 0;
            while (gnt !== 3'b000 && n < 20) begin
                tick();
                n++;
            end
            chk("rr_gap", 8'(gnt), 8'h00);
        end
        req = 3'b000;
        m_nack = 1'b0;
        tick();
        // timeout in ADDR with no response (requester 1 next)
        req = 3'b010;
        tick();
        req = 3'b000;
        chk("to_gnt", 8'(gnt), 8'h02);
        tick();
        tick();
        n = 0;
        do begin
            tick();
            n++;
        end while (done === 3'b000 && n < 20);
        chk("to_cycles", 8'(n), 8'd8);
        chk("to_done", 8'(done), 8'h02);
        chk("to_err", 8'(err), 8'h02);
        tick();
        // reset while in DATA
        req = 3'b001;
        tick();
        chk("rs_gnt", 8'(gnt), 8'h01);
        tick();
        tick();
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        chk("rs_in_data", m_data, 8'hC3);
        #2 rst = 1'b0;
        #1;
        chk("rs_gnt_zero", 8'(gnt), 8'h00);
        chk("rs_m_data_zero", m_data, 8'h00);
        chk("rs_done_zero", 8'(done), 8'h00);
        chk("rs_err_zero", 8'(err), 8'h00);
        tick();
        tick();
        chk("rs_no_done", 8'(done), 8'h00);
        req = 3'b111;
        rst = 1'b1;
        tick();
        chk("rs_first_gnt", 8'(gnt), 8'h01);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/i2c_master_scheduler.md
I2C_MASTER_SCHEDULER -- requirements
Module: i2c_master_scheduler

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning the maximum clk cycles allowed in any one of the ADDR, DATA or WAIT states before the transaction is aborted.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port req, input, 3 bits: per-requester transaction request, level-sensitive.
REQ-005 Port req_rw, input, 3 bits: per-requester direction; 1 = read, 0 = write.
REQ-006 Port req_addr, input, 21 bits: three 7-bit slave addresses; requester i occupies bits [7i+6:7i].
REQ-007 Port req_wdata, input, 24 bits: three write bytes; requester i occupies bits [8i+7:8i].
REQ-008 Port gnt, output, 3 bits: one-hot grant, or all zero when no transaction is in progress.
REQ-009 Port done, output, 3 bits: one-cycle completion pulse to the granted requester.
REQ-010 Port err, output, 3 bits: error flag, valid only in the same cycle as done.
REQ-011 Port rdata, output, 8 bits: read byte, valid in the same cycle as done.
REQ-012 Port m_start, output, 1 bit: start command to the I2C master.
REQ-013 Port m_data, output, 8 bits: byte presented to the master, either {addr, rw} or the write byte.
REQ-014 Port m_idle, input, 1 bit: high while the master is in its IDLE state.
REQ-015 Port m_ack, input, 1 bit: one-cycle pulse when the master enters its ACK state.
REQ-016 Port m_nack, input, 1 bit: one-cycle pulse when the master enters its NACK state.
REQ-017 Port m_rdata, input, 8 bits: the master's received byte.

Function
REQ-018 The FSM SHALL use the states IDLE, GRANT, START, ADDR, DATA, WAIT and DONE.
REQ-019 IDLE SHALL move to GRANT only when req is non-zero and m_idle is 1.
- The winner is chosen round-robin, searching from last+1 modulo 3.
- gnt is set one-hot in the same transition.
REQ-020 GRANT SHALL last 1 cycle, latch the winner's addr, rw and wdata into internal registers, and then go to START.
REQ-021 START SHALL last 1 cycle, drive m_start=1 and m_data={addr, rw}, and then go to ADDR.
- m_start is 0 in every other state.
REQ-022 In ADDR, m_data SHALL hold {addr, rw}, with these exits:
- m_ack while rw=0 goes to DATA.
- m_ack while rw=1 goes to WAIT.
- m_nack goes to DONE with the error flag set.
REQ-023 In DATA, m_data SHALL hold the latched wdata, with these exits:
- m_ack goes to WAIT.
- m_nack goes to DONE with the error flag set.
REQ-024 WAIT SHALL go to DONE on the first cycle m_idle=1.
- On that cycle, if rw=1, m_rdata is captured into the internal read register.
REQ-025 DONE SHALL last 1 cycle and do all of the following:
- Assert done[i]=1 and err[i]=(error flag).
- Drive rdata from the captured value, or 0 for a write.
- Clear gnt to 0 at exit.
- Set last=i.
- Go to IDLE.
REQ-026 A timeout counter SHALL clear on every state change and increment each cycle in ADDR, DATA and WAIT.
- When it reaches TIMEOUT, the FSM goes to DONE with the error flag set.
- m_ack or m_nack arriving in the same cycle takes priority over the timeout.
REQ-027 m_data SHALL hold its last value in WAIT, DONE and IDLE, and is reset to 8'h00.
REQ-028 Changes on req, req_rw, req_addr or req_wdata after GRANT, including req deassertion, SHALL NOT affect the transaction in progress.
REQ-029 A requester whose req stays high after its done pulse SHALL be re-granted only after the other active requesters have each been served once.
REQ-030 m_ack or m_nack arriving in IDLE, GRANT, START, WAIT or DONE SHALL be ignored.
REQ-031 When m_ack and m_nack are both high in the same cycle, m_nack SHALL take priority.

Reset
REQ-032 While rst=0, the block SHALL immediately, and independently of clk, force all of the following:
- state to IDLE;
- gnt, done, err, rdata, m_start and m_data to 0;
- the timeout counter to 0;
- last to 2, so that requester 0 has first priority.
REQ-033 A reset asserted mid-transaction SHALL abort the transaction without any done pulse; the requester must re-request.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- Write: req=001, rw=0, addr0=7'h2A, wdata0=8'hC3, m_idle=1, m_ack after START and again after DATA. Required: gnt=001; m_start pulses once with m_data=8'h54; m_data then becomes 8'hC3; done=001, err=000.
- Read: req=010, rw=1, addr1=7'h11, m_rdata=8'h5A. Required: m_data=8'h23; the flow skips DATA; done=010, rdata=8'h5A.
- NACK: m_nack in ADDR. Required: DONE on the next cycle with done=err=the granted bit; no DATA state is entered.
- Round-robin: req=111 held throughout. Required: grant order 001, 010, 100, 001, with gnt=000 for at least one cycle between grants.
- Timeout: TIMEOUT=8 and no m_ack after START. Required: done and err asserted exactly 8 cycles after ADDR entry.
- Reset mid-transaction: rst=0 while in DATA. Required: all outputs 0 at once; no done pulse; the next grant goes to requester 0 when req=111.
